// File: rtl/kamus_pkg.sv
// Shared load/store definitions: FSM states, access sizes and funct3 encodings.
package kamus_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10
  } lsu_state_t;

  // Access size as encoded in funct3[1:0]; the value 2'b11 is not a legal size.
  typedef enum logic [1:0] {
    LSU_B = 2'b00,
    LSU_H = 2'b01,
    LSU_W = 2'b10
  } lsu_size_t;

  // funct3 encodings for loads/stores, shared with the decoder.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/kamus_lsu_align.sv
// Combinational lane logic: byte enables, store replication, misalignment
// detection on the request side and load extraction/extension on the response side.
module kamus_lsu_align
  import kamus_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      req_size,
  input  logic [1:0]      req_off,
  input  logic [XLEN-1:0] req_wdata,
  output logic [3:0]      req_be,
  output logic [XLEN-1:0] req_wdata_rep,
  output logic            req_misaligned,
  input  lsu_size_t       ld_size,
  input  logic            ld_unsigned,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] ld_shifted;

  assign ld_shifted = ld_rdata >> {ld_off, 3'b000};

  // Request side: lane enables and replicated store data; size 11 is always illegal.
  always_comb begin
    req_be         = 4'b0000;
    req_wdata_rep  = req_wdata;
    req_misaligned = 1'b0;
    case (req_size)
      LSU_B: begin
        req_be        = 4'b0001 << req_off;
        req_wdata_rep = {(XLEN/8){req_wdata[7:0]}};
      end
      LSU_H: begin
        req_be         = 4'b0011 << req_off;
        req_wdata_rep  = {(XLEN/16){req_wdata[15:0]}};
        req_misaligned = req_off[0];
      end
      LSU_W: begin
        req_be         = 4'b1111;
        req_misaligned = (req_off != 2'b00);
      end
      default: req_misaligned = 1'b1;
    endcase
  end

  // Response side: the addressed bytes arrive in the low lanes after the shift.
  always_comb begin
    ld_data = ld_shifted;
    case (ld_size)
      LSU_B: ld_data = ld_unsigned ? {{(XLEN-8){1'b0}}, ld_shifted[7:0]}
                                   : {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
      LSU_H: ld_data = ld_unsigned ? {{(XLEN-16){1'b0}}, ld_shifted[15:0]}
                                   : {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/kamus_lsu.sv
// Load/store unit: accepts one memory op from execute, runs the L1D
// request/grant/response handshake and returns aligned load data.
module kamus_lsu
  import kamus_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  input  logic            l1d_wr_en_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            stall_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            rdata_valid_o,
  output logic            misaligned_o,
  output logic            l1d_req_o,
  output logic            l1d_we_o,
  output logic [XLEN-1:0] l1d_addr_o,
  output logic [3:0]      l1d_be_o,
  output logic [XLEN-1:0] l1d_wdata_o,
  input  logic            l1d_gnt_i,
  input  logic            l1d_rvalid_i,
  input  logic [XLEN-1:0] l1d_rdata_i
);

  lsu_state_t      state_reg;
  logic            we_reg;
  lsu_size_t       size_reg;
  logic            ld_unsigned_reg;
  logic [1:0]      off_reg;
  logic [XLEN-1:0] addr_reg;
  logic [3:0]      be_reg;
  logic [XLEN-1:0] wdata_reg;
  logic            req_reg;
  logic [XLEN-1:0] rdata_reg;
  logic            rdata_valid_reg;
  logic            misaligned_reg;

  logic [3:0]      req_be;
  logic [XLEN-1:0] req_wdata_rep;
  logic            req_misaligned;
  logic [XLEN-1:0] ld_data;

  kamus_lsu_align #(.XLEN(XLEN)) u_align (
    .req_size       (funct3_i[1:0]),
    .req_off        (addr_i[1:0]),
    .req_wdata      (wdata_i),
    .req_be         (req_be),
    .req_wdata_rep  (req_wdata_rep),
    .req_misaligned (req_misaligned),
    .ld_size        (size_reg),
    .ld_unsigned    (ld_unsigned_reg),
    .ld_off         (off_reg),
    .ld_rdata       (l1d_rdata_i),
    .ld_data        (ld_data)
  );

  // Upstream must freeze the cycle an aligned op is accepted, not for misaligned ones.
  assign stall_o = (state_reg != LSU_IDLE) || (req_valid_i && !req_misaligned);

  assign rdata_o       = rdata_reg;
  assign rdata_valid_o = rdata_valid_reg;
  assign misaligned_o  = misaligned_reg;
  assign l1d_req_o     = req_reg;
  assign l1d_we_o      = we_reg;
  assign l1d_addr_o    = addr_reg;
  assign l1d_be_o      = be_reg;
  assign l1d_wdata_o   = wdata_reg;

  // Handshake FSM; the l1d_* request fields are latched at accept so they stay stable in REQ.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= LSU_IDLE;
      we_reg          <= 1'b0;
      size_reg        <= LSU_B;
      ld_unsigned_reg <= 1'b0;
      off_reg         <= 2'b00;
      addr_reg        <= '0;
      be_reg          <= 4'b0000;
      wdata_reg       <= '0;
      req_reg         <= 1'b0;
      rdata_reg       <= '0;
      rdata_valid_reg <= 1'b0;
      misaligned_reg  <= 1'b0;
    end else begin
      rdata_valid_reg <= 1'b0;
      misaligned_reg  <= 1'b0;
      case (state_reg)
        LSU_IDLE: begin
          if (req_valid_i) begin
            if (req_misaligned) begin
              misaligned_reg <= 1'b1;
            end else begin
              we_reg          <= l1d_wr_en_i;
              size_reg        <= lsu_size_t'(funct3_i[1:0]);
              ld_unsigned_reg <= funct3_i[2];
              off_reg         <= addr_i[1:0];
              addr_reg        <= {addr_i[XLEN-1:2], 2'b00};
              be_reg          <= req_be;
              wdata_reg       <= req_wdata_rep;
              req_reg         <= 1'b1;
              state_reg       <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          if (l1d_gnt_i) begin
            req_reg   <= 1'b0;
            state_reg <= LSU_WAIT;
          end
        end
        LSU_WAIT: begin
          if (l1d_rvalid_i) begin
            state_reg <= LSU_IDLE;
            if (!we_reg) begin
              rdata_reg       <= ld_data;
              rdata_valid_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= LSU_IDLE;
      endcase
    end
  end

endmodule
